axi3_slave_write_mem: RTL and testbench

AXI3 slave write-path engine with an internal word-addressed memory. It sits directly downstream of the `AXI` interface's `slave` modport and consumes the AW, W and B channels. It accepts one write burst at a time, computes FIXED/INCR/WRAP beat addresses, applies byte-strobed writes, and returns one write response per burst. A registered debug read port lets benches and emulation probes inspect memory contents.

---
 rtl/axi3_slave_write_mem.sv | 205 ++++++++++++++++++++
 tb/tb_axi3_slave_write_mem.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi3_slave_write_mem.sv
`default_nettype none
// ============================================================================
// Module      : axi3_slave_write_mem
// Description : AXI3 slave write engine (AW/W/B) backed by a word-addressed
//               memory with byte strobes and a registered debug read port.
// Revision    : 1.0 - initial release
// ============================================================================
module axi3_slave_write_mem #(
    parameter int MEM_WORDS = 1024
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    input  logic                         AWVALID,
    output logic                         AWREADY,
    input  logic [3:0]                   AWID,
    input  logic [31:0]                  AWADDR,
    input  logic [3:0]                   AWLEN,
    input  logic [2:0]                   AWSIZE,
    input  logic [1:0]                   AWBURST,
    input  logic                         WVALID,
    output logic                         WREADY,
    input  logic [3:0]                   WID,
    input  logic [31:0]                  WDATA,
    input  logic [3:0]                   WSTRB,
    input  logic                         WLAST,
    output logic                         BVALID,
    input  logic                         BREADY,
    output logic [3:0]                   BID,
    output logic [1:0]                   BRESP,
    input  logic [$clog2(MEM_WORDS)-1:0] dbg_addr,
    output logic [31:0]                  dbg_rdata
);

    localparam int          c_AW        = $clog2(MEM_WORDS);
    localparam logic [29:0] c_WORDS_LIM = 30'(MEM_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        awready_q, awready_d;
    logic        wready_q, wready_d;
    logic        bvalid_q, bvalid_d;
    logic [3:0]  bid_q, bid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic [3:0]  id_q, id_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  len_q, len_d;
    logic [2:0]  size_q, size_d;
    logic [1:0]  burst_q, burst_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        slverr_q, slverr_d;
    logic        decerr_q, decerr_d;
    logic        badburst_q, badburst_d;
    logic [31:0] dbg_rdata_q;

    logic [31:0] mem [MEM_WORDS];

    logic [31:0] w_bytes;
    logic [31:0] w_total;
    logic [31:0] w_next_addr;
    logic        w_beat;
    logic        w_final;
    logic        w_oob;
    logic        w_we;
    logic        w_bad_aw;
    logic [c_AW-1:0] w_widx;

    always_comb begin
        w_bytes = 32'd1 << size_q;
        w_total = ({28'd0, len_q} + 32'd1) << size_q;
        case (burst_q)
            2'b01:   w_next_addr = (addr_q & ~(w_bytes - 32'd1)) + w_bytes;
            2'b10:   w_next_addr = (addr_q & ~(w_total - 32'd1)) |
                                   ((addr_q + w_bytes) & (w_total - 32'd1));
            default: w_next_addr = addr_q;
        endcase
        w_beat   = (state_q == S_DATA) && WVALID && wready_q;
        w_final  = (cnt_q == len_q);
        w_oob    = (addr_q[31:2] >= c_WORDS_LIM);
        w_we     = w_beat && !badburst_q && !w_oob && !ARESET;
        w_widx   = addr_q[c_AW+1:2];
        // Illegal descriptors still consume all beats but never touch memory.
        w_bad_aw = (AWSIZE > 3'd2) || (AWBURST == 2'b11) ||
                   ((AWBURST == 2'b10) &&
                    !((AWLEN == 4'd1) || (AWLEN == 4'd3) ||
                      (AWLEN == 4'd7) || (AWLEN == 4'd15)));
    end

    always_comb begin
        state_d    = state_q;
        bid_d      = bid_q;
        bresp_d    = bresp_q;
        id_d       = id_q;
        addr_d     = addr_q;
        len_d      = len_q;
        size_d     = size_q;
        burst_d    = burst_q;
        cnt_d      = cnt_q;
        slverr_d   = slverr_q;
        decerr_d   = decerr_q;
        badburst_d = badburst_q;
        case (state_q)
            S_IDLE: begin
                if (AWVALID && awready_q) begin
                    id_d       = AWID;
                    addr_d     = AWADDR;
                    len_d      = AWLEN;
                    size_d     = AWSIZE;
                    burst_d    = AWBURST;
                    cnt_d      = 4'd0;
                    slverr_d   = w_bad_aw;
                    decerr_d   = 1'b0;
                    badburst_d = w_bad_aw;
                    state_d    = S_DATA;
                end
            end
            S_DATA: begin
                if (w_beat) begin
                    addr_d = w_next_addr;
                    cnt_d  = cnt_q + 4'd1;
                    if ((WID != id_q) || (WLAST != w_final)) begin
                        slverr_d = 1'b1;
                    end
                    if (w_oob) begin
                        decerr_d = 1'b1;
                    end
                    // Burst length comes from the count; WLAST only feeds the error check.
                    if (w_final) begin
                        state_d = S_RESP;
                        bid_d   = id_q;
                        bresp_d = decerr_d ? 2'b11 : (slverr_d ? 2'b10 : 2'b00);
                    end
                end
            end
            S_RESP: begin
                if (bvalid_q && BREADY) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        awready_d = (state_d == S_IDLE);
        wready_d  = (state_d == S_DATA);
        bvalid_d  = (state_d == S_RESP);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= S_IDLE;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bid_q       <= 4'd0;
            bresp_q     <= 2'b00;
            id_q        <= 4'd0;
            addr_q      <= 32'd0;
            len_q       <= 4'd0;
            size_q      <= 3'd0;
            burst_q     <= 2'b00;
            cnt_q       <= 4'd0;
            slverr_q    <= 1'b0;
            decerr_q    <= 1'b0;
            badburst_q  <= 1'b0;
            dbg_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            bvalid_q    <= bvalid_d;
            bid_q       <= bid_d;
            bresp_q     <= bresp_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            cnt_q       <= cnt_d;
            slverr_q    <= slverr_d;
            decerr_q    <= decerr_d;
            badburst_q  <= badburst_d;
            dbg_rdata_q <= mem[dbg_addr];
        end
    end

    always_ff @(posedge ACLK) begin
        for (int i = 0; i < 4; i++) begin
            if (w_we && WSTRB[i]) begin
                mem[w_widx][8*i +: 8] <= WDATA[8*i +: 8];
            end
        end
    end

    assign AWREADY   = awready_q;
    assign WREADY    = wready_q;
    assign BVALID    = bvalid_q;
    assign BID       = bid_q;
    assign BRESP     = bresp_q;
    assign dbg_rdata = dbg_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_axi3_slave_write_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi3_slave_write_mem
// Description : Scoreboarded bench for axi3_slave_write_mem with directed and
//               randomized bursts against a behavioural memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi3_slave_write_mem;

    localparam int MW = 64;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [3:0]  AWID = '0;
    logic [31:0] AWADDR = '0;
    logic [3:0]  AWLEN = '0;
    logic [2:0]  AWSIZE = '0;
    logic [1:0]  AWBURST = '0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [3:0]  WID = '0;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        WLAST = 1'b0;
    logic        BVALID;
    logic        BREADY;
    logic [3:0]  BID;
    logic [1:0]  BRESP;
    logic [5:0]  dbg_addr = '0;
    logic [31:0] dbg_rdata;

    always #5 ACLK = ~ACLK;

    axi3_slave_write_mem #(.MEM_WORDS(MW)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWID(AWID), .AWADDR(AWADDR),
        .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .WVALID(WVALID), .WREADY(WREADY), .WID(WID), .WDATA(WDATA),
        .WSTRB(WSTRB), .WLAST(WLAST),
        .BVALID(BVALID), .BREADY(BREADY), .BID(BID), .BRESP(BRESP),
        .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata)
    );

    int          total = 0;
    int          bad = 0;
    int          b_seen = 0;
    int          n_bursts = 0;
    int          bready_delay = 0;
    logic [31:0] ref_mem [MW];
    bit          ref_valid [MW];
    logic [5:0]  exp_q [$];
    logic [31:0] data_a [16];
    logic [3:0]  strb_a [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Address of beat i derived directly from the burst rules (closed form).
    function automatic logic [31:0] beat_addr(input logic [31:0] start, input int i,
                                              input logic [3:0] len, input logic [2:0] size,
                                              input logic [1:0] burst);
        longint unsigned bytes, tot, base, s;
        bytes = 64'd1 << size;
        tot   = (64'(len) + 64'd1) * bytes;
        s     = 64'(start);
        if (burst == 2'b01) begin
            if (i == 0) return start;
            return 32'((s / bytes) * bytes + 64'(i) * bytes);
        end
        if (burst == 2'b10) begin
            base = (s / tot) * tot;
            return 32'(base + ((s - base + 64'(i) * bytes) % tot));
        end
        return start;
    endfunction

    // B-channel monitor: pops the scoreboard on every response.
    initial begin
        logic [5:0] e;
        int         hold;
        BREADY = 1'b0;
        forever begin
            @(negedge ACLK);
            if (!ARESET && BVALID === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_b: got BVALID=1 with BID=%h expected no response", BID);
                    e = {BID, BRESP};
                end else begin
                    e = exp_q[0];
                end
                chk("bid", 32'(BID), 32'(e[5:2]));
                chk("bresp", 32'(BRESP), 32'(e[1:0]));
                hold = bready_delay;
                for (int k = 0; k < hold; k++) begin
                    @(negedge ACLK);
                    chk("b_hold_valid", 32'(BVALID), 32'd1);
                    chk("b_hold_bid", 32'(BID), 32'(e[5:2]));
                    chk("b_hold_bresp", 32'(BRESP), 32'(e[1:0]));
                end
                BREADY = 1'b1;
                @(posedge ACLK);
                #1 BREADY = 1'b0;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                b_seen++;
                @(negedge ACLK);
                chk("bvalid_after_b", 32'(BVALID), 32'd0);
                chk("awready_after_b", 32'(AWREADY), 32'd1);
            end
        end
    end

    task automatic apply_beat(input int w, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++) begin
            if (s[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
        end
        if (s == 4'hF) ref_valid[w] = 1'b1;
    endtask

    task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input bit gaps,
                             input int bad_wid, input int bad_last, input int abort_after,
                             input bit early_w, input bit hold_aw);
        bit          bad_b, slv, dec, old_valid;
        logic [31:0] a, old_w;
        int          t, lw;
        bad_b = (size > 3'd2) || (burst == 2'b11) ||
                ((burst == 2'b10) && !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15));
        slv = bad_b || (bad_wid >= 0) || (bad_last >= 0);
        dec = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            a = beat_addr(addr, i, len, size, burst);
            if (a[31:2] >= 30'(MW)) dec = 1'b1;
        end
        exp_q.push_back({id, dec ? 2'b11 : (slv ? 2'b10 : 2'b00)});
        n_bursts++;
        if (early_w) begin
            WVALID = 1'b1; WID = id; WDATA = data_a[0]; WSTRB = strb_a[0]; WLAST = (len == 4'd0);
            @(negedge ACLK);
            chk("wready_before_aw", 32'(WREADY), 32'd0);
            @(posedge ACLK); #1;
        end
        AWVALID = 1'b1; AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst;
        t = 0;
        do begin @(negedge ACLK); t++; end while (AWREADY !== 1'b1 && t < 40);
        chk("aw_handshake", 32'(AWREADY), 32'd1);
        if (AWREADY !== 1'b1) begin AWVALID = 1'b0; WVALID = 1'b0; return; end
        @(posedge ACLK); #1;
        if (!hold_aw) AWVALID = 1'b0;
        WVALID = 1'b0;
        @(negedge ACLK);
        chk("awready_in_data", 32'(AWREADY), 32'd0);
        chk("wready_in_data", 32'(WREADY), 32'd1);
        @(posedge ACLK); #1;
        lw = -1; old_w = '0; old_valid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            if (gaps) begin WVALID = 1'b0; @(posedge ACLK); #1; end
            WVALID = 1'b1;
            WID    = (i == bad_wid) ? ~id : id;
            WDATA  = data_a[i];
            WSTRB  = strb_a[i];
            WLAST  = (i == int'(len)) != (i == bad_last);
            t = 0;
            do begin @(negedge ACLK); t++; end while (WREADY !== 1'b1 && t < 40);
            chk("w_handshake", 32'(WREADY), 32'd1);
            if (WREADY !== 1'b1) begin WVALID = 1'b0; return; end
            a  = beat_addr(addr, i, len, size, burst);
            lw = -1;
            if (a[31:2] < 30'(MW)) begin
                lw = int'(a[31:2]);
                old_w = ref_mem[lw];
                old_valid = ref_valid[lw];
                if (!bad_b) apply_beat(lw, data_a[i], strb_a[i]);
            end
            @(posedge ACLK); #1;
            if (abort_after == i + 1) begin WVALID = 1'b0; return; end
        end
        WVALID = 1'b0; WLAST = 1'b0;
        @(negedge ACLK);
        chk("wready_after_last", 32'(WREADY), 32'd0);
        chk("bvalid_after_last", 32'(BVALID), 32'd1);
        if (lw >= 0 && int'(dbg_addr) == lw && old_valid)
            chk("dbg_read_before_write", dbg_rdata, old_w);
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        if (lw >= 0 && int'(dbg_addr) == lw && ref_valid[lw]) begin
            @(negedge ACLK);
            chk("dbg_after_write", dbg_rdata, ref_mem[lw]);
            @(posedge ACLK); #1;
        end
    endtask

    task automatic read_word(input int w, output logic [31:0] d);
        dbg_addr = 6'(w);
        @(posedge ACLK);
        @(negedge ACLK);
        d = dbg_rdata;
        @(posedge ACLK); #1;
    endtask

    task automatic check_mem();
        logic [31:0] d;
        for (int w = 0; w < MW; w++) begin
            if (ref_valid[w]) begin
                read_word(w, d);
                chk($sformatf("mem[%0d]", w), d, ref_mem[w]);
            end
        end
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < 16; i++) begin
            data_a[i] = $urandom;
            strb_a[i] = (i < n) ? 4'hF : 4'h0;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [3:0]  lens [4];
        logic [3:0]  rl;
        logic [1:0]  rb;
        logic [2:0]  rs;
        int          t;
        lens[0] = 4'd1; lens[1] = 4'd3; lens[2] = 4'd7; lens[3] = 4'd15;
        for (int w = 0; w < MW; w++) begin ref_mem[w] = '0; ref_valid[w] = 1'b0; end

        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk("rst_awready", 32'(AWREADY), 32'd0);
        chk("rst_wready", 32'(WREADY), 32'd0);
        chk("rst_bvalid", 32'(BVALID), 32'd0);
        chk("rst_bid", 32'(BID), 32'd0);
        chk("rst_bresp", 32'(BRESP), 32'd0);
        chk("rst_dbg_rdata", dbg_rdata, 32'd0);
        @(posedge ACLK); #1 ARESET = 1'b0;
        @(negedge ACLK);
        chk("awready_release_cycle", 32'(AWREADY), 32'd0);
        @(negedge ACLK);
        chk("awready_first_cycle", 32'(AWREADY), 32'd1);
        @(posedge ACLK); #1;

        for (int blk = 0; blk < 4; blk++) begin
            fill_random(16);
            run_burst(4'(blk), 32'(blk * 64), 4'd15, 3'd2, 2'b01, 1'b0, -1, -1, -1, 1'b0, 1'b0);
        end
        check_mem();

        fill_random(1);
        data_a[0] = 32'hDEADBEEF;
        dbg_addr  = 6'd4;
        run_burst(4'h5, 32'h10, 4'd0, 3'd2, 2'b01, 1'b0, -1, -1, -1, 1'b1, 1'b0);
        read_word(4, d);
        chk("single_mem4", d, 32'hDEADBEEF);

        fill_random(4);
        for (int i = 0; i < 4; i++) data_a[i] = 32'(i + 1);
        run_burst(4'h3, 32'h38, 4'd3, 3'd2, 2'b10, 1'b0, -1, -1, -1, 1'b0, 1'b0);
        read_word(14, d); chk("wrap_mem14", d, 32'd1);
        read_word(15, d); chk("wrap_mem15", d, 32'd2);
        read_word(12, d); chk("wrap_mem12", d, 32'd3);
        read_word(13, d); chk("wrap_mem13", d, 32'd4);

        fill_random(1);
        data_a[0] = 32'h0;
        run_burst(4'h1, 32'h0, 4'd0, 3'd2, 2'b01, 1'b0, -1, -1, -1, 1'b0, 1'b0);
        data_a[0] = 32'h11111111; strb_a[0] = 4'b0001;
        data_a[1] = 32'h22222222; strb_a[1] = 4'b0100;
        run_burst(4'h2, 32'h0, 4'd1, 3'd2, 2'b00, 1'b0, -1, -1, -1, 1'b0, 1'b0);
        read_word(0, d);
        chk("fixed_strobe_mem0", d, 32'h00220011);

        fill_random(4);
        run_burst(4'h7, 32'h80, 4'd3, 3'd2, 2'b01, 1'b0, 1, -1, -1, 1'b0, 1'b0);
        fill_random(1);
        run_burst(4'h9, 32'(MW * 4), 4'd0, 3'd2, 2'b01, 1'b0, -1, -1, -1, 1'b0, 1'b0);
        fill_random(2);
        run_burst(4'hA, 32'h0, 4'd1, 3'd3, 2'b01, 1'b0, -1, -1, -1, 1'b0, 1'b0);
        fill_random(4);
        run_burst(4'hB, 32'h40, 4'd3, 3'd2, 2'b01, 1'b0, -1, 0, -1, 1'b0, 1'b0);
        check_mem();

        bready_delay = 5;
        fill_random(8);
        run_burst(4'hC, 32'h20, 4'd7, 3'd2, 2'b01, 1'b1, -1, -1, -1, 1'b0, 1'b1);
        t = 0;
        while (exp_q.size() != 0 && t < 40) begin @(posedge ACLK); t++; end
        #1;
        chk("backpressure_b_done", 32'(exp_q.size()), 32'd0);
        bready_delay = 0;

        fill_random(8);
        run_burst(4'hD, 32'h60, 4'd7, 3'd2, 2'b01, 1'b0, -1, -1, 2, 1'b0, 1'b0);
        ARESET = 1'b1;
        if (exp_q.size() != 0) void'(exp_q.pop_back());
        n_bursts--;
        @(negedge ACLK);
        chk("rst_mid_bvalid", 32'(BVALID), 32'd0);
        @(posedge ACLK); #1;
        @(posedge ACLK); #1 ARESET = 1'b0;
        @(negedge ACLK);
        chk("rst_mid_bvalid_rel", 32'(BVALID), 32'd0);
        @(negedge ACLK);
        chk("rst_mid_awready", 32'(AWREADY), 32'd1);
        chk("rst_mid_bvalid_idle", 32'(BVALID), 32'd0);
        @(posedge ACLK); #1;
        fill_random(8);
        run_burst(4'hE, 32'h60, 4'd7, 3'd2, 2'b01, 1'b0, -1, -1, -1, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            rs = 3'($urandom_range(0, 2));
            rb = 2'($urandom_range(0, 2));
            rl = (rb == 2'b10) ? lens[$urandom_range(0, 3)] : 4'($urandom_range(0, 15));
            for (int i = 0; i < 16; i++) begin
                data_a[i] = $urandom;
                strb_a[i] = 4'($urandom);
            end
            bready_delay = $urandom_range(0, 3);
            run_burst(4'($urandom), 32'($urandom_range(0, MW * 4 + 64)), rl, rs, rb,
                      1'($urandom), ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, rl)) : -1,
                      ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, rl)) : -1,
                      -1, 1'b0, 1'b0);
        end

        t = 0;
        while (exp_q.size() != 0 && t < 60) begin @(posedge ACLK); t++; end
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("b_count", 32'(b_seen), 32'(n_bursts));
        check_mem();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
